seq_divider: RTL and testbench

- Multi-cycle unsigned integer divider producing quotient and remainder. It is the inverse-operation companion to the single-cycle ALU.
- Replaces the combinational A / B path for timing closure; the datapath control issues a request and stalls until done.
- Restoring algorithm, one quotient bit per clock, so the ALU result/flag convention (R, ZF) is kept on the output side.

---
 rtl/seq_divider_pkg.sv | 14 +
 rtl/seq_divider_if.sv | 24 ++
 rtl/seq_divider_div_step.sv | 30 +++
 rtl/seq_divider.sv | 110 +++++++++++
 tb/tb_seq_divider.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential restoring divider.
package seq_divider_pkg;

    // Default operand/result width.
    localparam int unsigned DivWidth = 32;

    // Divider FSM states.
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } div_state_e;

endpackage

// File: rtl/seq_divider_if.sv
// Request/result bundle between datapath control (master) and the divider (slave).
interface seq_divider_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] Q;
    logic [WIDTH-1:0] R;
    logic             ZF;
    logic             DZ;

    modport master (
        output start, A, B,
        input  busy, done, Q, R, ZF, DZ
    );

    modport slave (
        input  start, A, B,
        output busy, done, Q, R, ZF, DZ
    );
endinterface

// File: rtl/seq_divider_div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract.
module seq_divider_div_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH:0]   rem_i,
    input  logic [WIDTH-1:0] q_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH:0]   rem_o,
    output logic [WIDTH-1:0] q_o
);
    logic [WIDTH:0] partial;
    logic [WIDTH:0] diff;

    // The remainder stays below the divisor, so its top bit is always zero going in.
    logic unused_rem_msb;
    assign unused_rem_msb = rem_i[WIDTH];

    // Trial subtract at WIDTH+1 bits; keep the difference only if it does not go negative.
    always_comb begin
        partial = {rem_i[WIDTH-1:0], q_i[WIDTH-1]};
        diff    = partial - {1'b0, divisor_i};
        if (partial >= {1'b0, divisor_i}) begin
            rem_o = diff;
            q_o   = {q_i[WIDTH-2:0], 1'b1};
        end else begin
            rem_o = partial;
            q_o   = {q_i[WIDTH-2:0], 1'b0};
        end
    end
endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned divider: one quotient bit per clock, registered Q/R/ZF/DZ.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int unsigned WIDTH = DivWidth,
    parameter int unsigned CNT_W = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    seq_divider_if.slave  bus
);
    div_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [WIDTH:0]   rem_q;
    logic [WIDTH:0]   rem_d;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] quo_d;
    logic [WIDTH-1:0] div_q;
    logic [WIDTH-1:0] q_out_q;
    logic [WIDTH-1:0] r_out_q;
    logic             zf_q;
    logic             dz_q;
    logic             busy_q;
    logic             done_q;

    seq_divider_div_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .rem_i     (rem_q),
        .q_i       (quo_q),
        .divisor_i (div_q),
        .rem_o     (rem_d),
        .q_o       (quo_d)
    );

    // Iteration counter next value.
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
    end

    // FSM, datapath registers and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            div_q   <= '0;
            q_out_q <= '0;
            r_out_q <= '0;
            zf_q    <= 1'b1;
            dz_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        quo_q  <= bus.A;
                        div_q  <= bus.B;
                        rem_q  <= '0;
                        cnt_q  <= '0;
                        dz_q   <= 1'b0;
                        busy_q <= 1'b1;
                        if (bus.B == '0) begin
                            // Divide by zero: skip iterating, report saturated quotient.
                            state_q <= StDone;
                            done_q  <= 1'b1;
                            q_out_q <= '1;
                            r_out_q <= bus.A;
                            zf_q    <= 1'b0;
                            dz_q    <= 1'b1;
                        end else begin
                            state_q <= StRun;
                        end
                    end
                end
                StRun: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    cnt_q <= cnt_d;
                    if (cnt_d == CNT_W'(WIDTH)) begin
                        state_q <= StDone;
                        done_q  <= 1'b1;
                        q_out_q <= quo_d;
                        r_out_q <= rem_d[WIDTH-1:0];
                        zf_q    <= (quo_d == '0);
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.Q    = q_out_q;
    assign bus.R    = r_out_q;
    assign bus.ZF   = zf_q;
    assign bus.DZ   = dz_q;
endmodule

// File: tb/tb_seq_divider.sv
// Directed-vector and invariant bench for seq_divider.
module tb_seq_divider;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    seq_divider_if #(.WIDTH(32)) bus ();

    seq_divider #(
        .WIDTH (32),
        .CNT_W (6)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        logic        zf;
        logic        dz;
        int          lat;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issue one request in the current (IDLE) cycle; returns latency to done (0 on timeout).
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, output int lat,
                          output logic [31:0] q, output logic [31:0] r,
                          output logic zf, output logic dz);
        bus.A     = a;
        bus.B     = b;
        bus.start = 1'b1;
        lat       = 0;
        q         = '0;
        r         = '0;
        zf        = 1'b0;
        dz        = 1'b0;
        for (int n = 1; n <= 100; n++) begin
            @(posedge clk);
            #1;
            if (n == 1) begin
                bus.start = 1'b0;
                check("busy_after_accept", 64'(bus.busy), 64'd1);
            end
            if (bus.done) begin
                lat = n;
                q   = bus.Q;
                r   = bus.R;
                zf  = bus.ZF;
                dz  = bus.DZ;
                break;
            end
        end
        @(posedge clk);
        #1;
        check("done_single_cycle", 64'(bus.done), 64'd0);
        check("idle_after_done", 64'(bus.busy), 64'd0);
    endtask

    initial begin
        int          lat;
        int          ndone;
        logic [31:0] q;
        logic [31:0] r;
        logic [31:0] a;
        logic [31:0] b;
        logic        zf;
        logic        dz;
        logic        ok;

        n_cmp = 0;
        n_err = 0;
        vecs[0] = '{32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0, 33};
        vecs[1] = '{32'd7, 32'd100, 32'd0, 32'd7, 1'b1, 1'b0, 33};
        vecs[2] = '{32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0, 1'b0, 1'b0, 33};
        vecs[3] = '{32'hFFFFFFFF, 32'h80000000, 32'd1, 32'h7FFFFFFF, 1'b0, 1'b0, 33};
        vecs[4] = '{32'd5, 32'd0, 32'hFFFFFFFF, 32'd5, 1'b0, 1'b1, 1};
        vecs[5] = '{32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 1'b0, 33};
        vecs[6] = '{32'd0, 32'd5, 32'd0, 32'd0, 1'b1, 1'b0, 33};
        vecs[7] = '{32'd123456789, 32'd1000, 32'd123456, 32'd789, 1'b0, 1'b0, 33};
        vecs[8] = '{32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 1'b1, 1'b0, 33};

        bus.start = 1'b0;
        bus.A     = '0;
        bus.B     = '0;
        rst_n     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_q", 64'(bus.Q), 64'd0);
        check("rst_r", 64'(bus.R), 64'd0);
        check("rst_zf", 64'(bus.ZF), 64'd1);
        check("rst_dz", 64'(bus.DZ), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed vectors, issued back-to-back.
        for (int i = 0; i < 9; i++) begin
            run_op(vecs[i].a, vecs[i].b, lat, q, r, zf, dz);
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
            check($sformatf("vec%0d_q", i), 64'(q), 64'(vecs[i].q));
            check($sformatf("vec%0d_r", i), 64'(r), 64'(vecs[i].r));
            check($sformatf("vec%0d_zf", i), 64'(zf), 64'(vecs[i].zf));
            check($sformatf("vec%0d_dz", i), 64'(dz), 64'(vecs[i].dz));
        end

        // Results hold while idle.
        run_op(32'd100, 32'd7, lat, q, r, zf, dz);
        for (int n = 0; n < 10; n++) begin
            check("hold_q", 64'(bus.Q), 64'd14);
            check("hold_r", 64'(bus.R), 64'd2);
            check("hold_done_low", 64'(bus.done), 64'd0);
            @(posedge clk);
            #1;
        end

        // A start pulse with new operands mid-division is ignored.
        bus.A     = 32'd100;
        bus.B     = 32'd7;
        bus.start = 1'b1;
        lat       = 0;
        for (int n = 1; n <= 100; n++) begin
            @(posedge clk);
            #1;
            if (n == 1) bus.start = 1'b0;
            if (n == 10) begin
                bus.start = 1'b1;
                bus.A     = 32'd1;
                bus.B     = 32'd1;
            end
            if (n == 11) bus.start = 1'b0;
            if (bus.done) begin
                lat = n;
                q   = bus.Q;
                r   = bus.R;
                break;
            end
        end
        check("busy_start_latency", 64'(lat), 64'd33);
        check("busy_start_q", 64'(q), 64'd14);
        check("busy_start_r", 64'(r), 64'd2);
        @(posedge clk);
        #1;
        check("busy_start_no_requeue", 64'(bus.busy), 64'd0);

        // Reset mid-flight abandons the division without a done.
        bus.A     = 32'd1000;
        bus.B     = 32'd3;
        bus.start = 1'b1;
        for (int n = 1; n <= 15; n++) begin
            @(posedge clk);
            #1;
            if (n == 1) bus.start = 1'b0;
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("midrst_busy", 64'(bus.busy), 64'd0);
        check("midrst_done", 64'(bus.done), 64'd0);
        check("midrst_q", 64'(bus.Q), 64'd0);
        check("midrst_r", 64'(bus.R), 64'd0);
        check("midrst_zf", 64'(bus.ZF), 64'd1);
        check("midrst_dz", 64'(bus.DZ), 64'd0);
        ndone = 0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk);
            #1;
            if (bus.done) ndone++;
        end
        check("midrst_no_done", 64'(ndone), 64'd0);

        // Random operands: check A == Q*B + R, R < B.
        for (int i = 0; i < 1000; i++) begin
            a = $urandom;
            b = $urandom;
            b = b >> $urandom_range(0, 31);
            if (b == 32'd0) b = 32'd1;
            run_op(a, b, lat, q, r, zf, dz);
            ok = ((64'(q) * 64'(b) + 64'(r)) == 64'(a)) && (r < b) && !dz && (zf == (q == 0));
            if (!ok) $display("FAIL random_operands: a=%0h b=%0h q=%0h r=%0h", a, b, q, r);
            check("random_invariant", 64'(ok), 64'd1);
            check("random_latency", 64'(lat), 64'd33);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
